sdram_frame_arbiter: RTL and testbench

Schedules 16-bit burst traffic between a write FIFO (pixel capture side) and a read FIFO (display side) onto the single-port SDRAM driver in the edge-detection pipeline. Generates burst addresses for triple-buffered frames held in SDRAM banks 0–2, so the display never reads a frame that is still being written. Issues one request at a time to the driver, feeds write data on acknowledge and collects read beats into the read FIFO.

---
 rtl/sdram_arb_pkg.sv | 47 ++++
 rtl/sdram_frame_addr.sv | 38 +++
 rtl/sdram_frame_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sdram_frame_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM frame arbiter: FSM encoding, default
// geometry, bank indices and the driver address layout.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_RD_REQ,
        ST_RD_DATA
    } arb_state_t;

    localparam int DEF_BL          = 8;
    localparam int DEF_FRAME_WORDS = 307200;
    localparam int DEF_RD_SPACE    = 256;

    localparam logic [1:0] BANK0 = 2'd0;
    localparam logic [1:0] BANK1 = 2'd1;
    localparam logic [1:0] BANK2 = 2'd2;

    // Driver address: {bank[1:0], row[12:0], col[8:0]}
    localparam int ADDR_W   = 24;
    localparam int OFF_W    = 22;
    localparam int BANK_MSB = 23;
    localparam int BANK_LSB = 22;
    localparam int ROW_MSB  = 21;
    localparam int ROW_LSB  = 9;
    localparam int COL_MSB  = 8;
    localparam int COL_LSB  = 0;

    // The one bank of {0,1,2} that is neither a nor b (a != b assumed).
    function automatic logic [1:0] free_bank(input logic [1:0] a, input logic [1:0] b);
        return 2'd3 - a - b;
    endfunction

    // Split a linear frame offset into row/col and prepend the bank.
    function automatic logic [ADDR_W-1:0] make_addr(input logic [1:0] bank,
                                                    input logic [OFF_W-1:0] off);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[BANK_MSB:BANK_LSB] = bank;
        a[ROW_MSB:ROW_LSB]   = off[OFF_W-1:COL_MSB+1];
        a[COL_MSB:COL_LSB]   = off[COL_MSB:0];
        return a;
    endfunction

endpackage

// File: rtl/sdram_frame_addr.sv
// Per-side frame offset counter: steps by one burst, wraps at end of frame
// and reports the wrap as a frame_end pulse in the completing cycle.
module sdram_frame_addr
    import sdram_arb_pkg::*;
#(
    parameter int BL          = DEF_BL,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_adv,
    output logic [OFF_W-1:0] o_off,
    output logic             o_frame_end
);

    localparam logic [OFF_W-1:0] STEP = OFF_W'(BL);
    localparam logic [OFF_W-1:0] LAST = OFF_W'(FRAME_WORDS - BL);

    logic [OFF_W-1:0] r_off;
    logic             w_last;

    assign w_last      = (r_off == LAST);
    assign o_off       = r_off;
    assign o_frame_end = i_adv & w_last;

    // Offset register: clear on frame sync, advance one burst per completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_off <= '0;
        end else if (i_clr) begin
            r_off <= '0;
        end else if (i_adv) begin
            r_off <= w_last ? '0 : r_off + STEP;
        end
    end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates capture writes and display reads onto the single-port SDRAM
// driver, one burst at a time, over a triple-buffered set of frames.
module sdram_frame_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int BL          = DEF_BL,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int RD_SPACE    = DEF_RD_SPACE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        wr_fifo_usedw,
    input  logic [15:0]       wr_fifo_q,
    output logic              wr_fifo_rdreq,
    input  logic              wr_frame_start,
    input  logic [9:0]        rd_fifo_usedw,
    output logic              rd_fifo_wrreq,
    output logic [15:0]       rd_fifo_data,
    input  logic              rd_en,
    input  logic              rd_frame_start,
    input  logic              drv_init_done,
    input  logic              drv_busy,
    input  logic              drv_ack,
    output logic              drv_wr_req,
    output logic              drv_rd_req,
    output logic [ADDR_W-1:0] drv_rw_addr,
    output logic [15:0]       drv_wr_din,
    output logic              drv_wr_din_vld,
    input  logic [15:0]       drv_rd_dout,
    input  logic              drv_rd_dout_vld,
    output logic [1:0]        wr_bank,
    output logic [1:0]        rd_bank
);

    localparam int CNT_W = $clog2(BL + 1);

    arb_state_t        r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_rd;
    logic              r_wr_pend, r_rd_pend;
    logic [1:0]        r_wr_bank, r_rd_bank, r_ready_bank;
    logic              r_wr_req, r_rd_req;
    logic [ADDR_W-1:0] r_addr;

    logic [OFF_W-1:0]  w_wr_off, w_rd_off, w_wr_off_eff, w_rd_off_eff;
    logic              w_wr_end, w_rd_end, w_wr_clr, w_rd_clr;
    logic              w_arb_en, w_wr_ok, w_rd_ok, w_grant_wr, w_grant_rd;
    logic              w_pop, w_push, w_wr_done, w_rd_done;

    // A pending frame sync is applied on entry to arbitration, so the grant
    // issued in that same cycle must already see the cleared offset.
    assign w_wr_clr     = (r_state == ST_IDLE) & r_wr_pend;
    assign w_rd_clr     = (r_state == ST_IDLE) & r_rd_pend;
    assign w_wr_off_eff = w_wr_clr ? '0 : w_wr_off;
    assign w_rd_off_eff = w_rd_clr ? '0 : w_rd_off;

    assign w_arb_en   = (r_state == ST_IDLE) & drv_init_done & ~drv_busy;
    assign w_wr_ok    = (wr_fifo_usedw >= 10'(BL));
    assign w_rd_ok    = rd_en & (rd_fifo_usedw <= 10'(RD_SPACE));
    assign w_grant_wr = w_arb_en & w_wr_ok & (~w_rd_ok | r_last_rd);
    assign w_grant_rd = w_arb_en & w_rd_ok & (~w_wr_ok | ~r_last_rd);

    assign w_push    = (r_state == ST_RD_DATA) & drv_rd_dout_vld;
    assign w_wr_done = (r_state == ST_WR_DATA) & (r_cnt == CNT_W'(BL - 2));
    assign w_rd_done = w_push & (r_cnt == CNT_W'(BL - 1));

    // Data paths are zeroed when idle so every output rests at 0.
    assign wr_fifo_rdreq  = w_pop;
    assign drv_wr_din_vld = w_pop;
    assign drv_wr_din     = w_pop ? wr_fifo_q : '0;
    assign rd_fifo_wrreq  = w_push;
    assign rd_fifo_data   = w_push ? drv_rd_dout : '0;
    assign drv_wr_req     = r_wr_req;
    assign drv_rd_req     = r_rd_req;
    assign drv_rw_addr    = r_addr;
    assign wr_bank        = r_wr_bank;
    assign rd_bank        = r_rd_bank;

    sdram_frame_addr #(.BL(BL), .FRAME_WORDS(FRAME_WORDS)) u_wr_addr (
        .clk(clk), .rst_n(rst_n), .i_clr(w_wr_clr), .i_adv(w_wr_done),
        .o_off(w_wr_off), .o_frame_end(w_wr_end)
    );

    sdram_frame_addr #(.BL(BL), .FRAME_WORDS(FRAME_WORDS)) u_rd_addr (
        .clk(clk), .rst_n(rst_n), .i_clr(w_rd_clr), .i_adv(w_rd_done),
        .o_off(w_rd_off), .o_frame_end(w_rd_end)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state and write-FIFO pop; the ack cycle already carries word 0.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_wr)      w_state_next = ST_WR_REQ;
                else if (w_grant_rd) w_state_next = ST_RD_REQ;
            end
            ST_WR_REQ: begin
                if (drv_ack) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                w_pop = 1'b1;
                if (w_wr_done) w_state_next = ST_IDLE;
            end
            ST_RD_REQ: begin
                if (drv_ack) w_state_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (w_rd_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Burst word counter: pops in WR_DATA, accepted beats in RD_DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == ST_WR_DATA) || w_push) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (r_state != ST_RD_DATA) begin
            r_cnt <= '0;
        end
    end

    // Registered request/address toward the driver and fairness memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_req  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_addr    <= '0;
            r_last_rd <= 1'b1;
        end else begin
            if (w_grant_wr) begin
                r_wr_req  <= 1'b1;
                r_addr    <= make_addr(r_wr_bank, w_wr_off_eff);
                r_last_rd <= 1'b0;
            end else if (w_grant_rd) begin
                r_rd_req  <= 1'b1;
                r_addr    <= make_addr(r_rd_bank, w_rd_off_eff);
                r_last_rd <= 1'b1;
            end
            if ((r_state == ST_WR_REQ) && drv_ack) r_wr_req <= 1'b0;
            if ((r_state == ST_RD_REQ) && drv_ack) r_rd_req <= 1'b0;
        end
    end

    // Frame-sync pending flags and triple-buffer bank rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_pend    <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_wr_bank    <= BANK0;
            r_rd_bank    <= BANK2;
            r_ready_bank <= BANK2;
        end else begin
            r_wr_pend <= wr_frame_start | (r_wr_pend & ~w_wr_clr);
            r_rd_pend <= rd_frame_start | (r_rd_pend & ~w_rd_clr);
            if (w_wr_end) begin
                r_ready_bank <= r_wr_bank;
                r_wr_bank    <= free_bank(r_wr_bank, r_rd_bank);
            end
            if (w_rd_end) begin
                r_rd_bank <= r_ready_bank;
            end
        end
    end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for sdram_frame_arbiter with a 16-word frame (two bursts).
module tb_sdram_frame_arbiter;

    localparam int BL = 8;
    localparam int FW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  wr_fifo_usedw = '0;
    logic [15:0] wr_fifo_q = '0;
    logic        wr_fifo_rdreq;
    logic        wr_frame_start = 1'b0;
    logic [9:0]  rd_fifo_usedw = '0;
    logic        rd_fifo_wrreq;
    logic [15:0] rd_fifo_data;
    logic        rd_en = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic        drv_init_done = 1'b0;
    logic        drv_busy = 1'b0;
    logic        drv_ack = 1'b0;
    logic        drv_wr_req, drv_rd_req;
    logic [23:0] drv_rw_addr;
    logic [15:0] drv_wr_din;
    logic        drv_wr_din_vld;
    logic [15:0] drv_rd_dout = '0;
    logic        drv_rd_dout_vld = 1'b0;
    logic [1:0]  wr_bank, rd_bank;

    int checks = 0;
    int errors = 0;

    logic [23:0] arb_addr [4] = '{24'h000008, 24'h800008, 24'h400000, 24'h000000};
    logic        arb_rd   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    sdram_frame_arbiter #(.BL(BL), .FRAME_WORDS(FW), .RD_SPACE(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_fifo_usedw(wr_fifo_usedw), .wr_fifo_q(wr_fifo_q), .wr_fifo_rdreq(wr_fifo_rdreq),
        .wr_frame_start(wr_frame_start),
        .rd_fifo_usedw(rd_fifo_usedw), .rd_fifo_wrreq(rd_fifo_wrreq), .rd_fifo_data(rd_fifo_data),
        .rd_en(rd_en), .rd_frame_start(rd_frame_start),
        .drv_init_done(drv_init_done), .drv_busy(drv_busy), .drv_ack(drv_ack),
        .drv_wr_req(drv_wr_req), .drv_rd_req(drv_rd_req), .drv_rw_addr(drv_rw_addr),
        .drv_wr_din(drv_wr_din), .drv_wr_din_vld(drv_wr_din_vld),
        .drv_rd_dout(drv_rd_dout), .drv_rd_dout_vld(drv_rd_dout_vld),
        .wr_bank(wr_bank), .rd_bank(rd_bank)
    );

    // Plays the driver for one burst: waits for a request, acks it, then
    // supplies BL read beats or lets BL write words drain. Returns at the
    // falling edge of the first idle cycle after the burst.
    task automatic serve_burst(input bit pulse, output bit got, output bit is_rd,
                               output logic [23:0] addr, output int waited);
        got = 1'b0; is_rd = 1'b0; addr = '0; waited = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            waited = i + 1;
            got = drv_wr_req | drv_rd_req;
        end
        if (got) begin
            is_rd = drv_rd_req;
            addr  = drv_rw_addr;
            drv_ack = 1'b1;
            @(negedge clk);
            drv_ack = 1'b0;
            if (is_rd) begin
                for (int k = 0; k < BL; k++) begin
                    drv_rd_dout_vld = 1'b1;
                    drv_rd_dout = 16'hC000 + 16'(k);
                    @(negedge clk);
                end
                drv_rd_dout_vld = 1'b0;
            end else begin
                wr_frame_start = pulse;
                @(negedge clk);
                wr_frame_start = 1'b0;
                repeat (BL - 2) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_fifo_q = 16'h1234; drv_rd_dout = 16'h5678;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({wr_fifo_rdreq, rd_fifo_wrreq, drv_wr_req, drv_rd_req, drv_wr_din_vld} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {wr_fifo_rdreq, rd_fifo_wrreq, drv_wr_req, drv_rd_req, drv_wr_din_vld});
        end
        checks++;
        if (drv_rw_addr !== 24'h0 || drv_wr_din !== 16'h0 || rd_fifo_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_data addr=%h din=%h rdata=%h exp=0", drv_rw_addr, drv_wr_din, rd_fifo_data);
        end
        checks++;
        if (wr_bank !== 2'd0 || rd_bank !== 2'd2) begin
            errors++;
            $display("FAIL reset_banks wr=%0d rd=%0d exp wr=0 rd=2", wr_bank, rd_bank);
        end
        $display("reset: wr_bank=%0d rd_bank=%0d", wr_bank, rd_bank);
        @(negedge clk);
        rst_n = 1'b1; wr_fifo_q = '0; drv_rd_dout = '0;
    endtask

    task automatic test_init_gating();
        int bad, pops, dbad, seqbad;
        bad = 0; pops = 0; dbad = 0; seqbad = 0;
        wr_fifo_usedw = 10'd20; drv_init_done = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            if (drv_wr_req | drv_rd_req) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL init_gate req_cycles=%0d exp=0", bad); end
        drv_init_done = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (drv_wr_req !== 1'b1 || drv_rw_addr !== 24'h000000) begin
            errors++;
            $display("FAIL init_req wr_req=%b addr=%h exp 1/000000", drv_wr_req, drv_rw_addr);
        end
        drv_ack = 1'b1; wr_fifo_q = 16'hA000; wr_fifo_usedw = '0;
        #1;
        checks++;
        if (wr_fifo_rdreq !== 1'b1 || drv_wr_din_vld !== 1'b1 || drv_wr_din !== 16'hA000) begin
            errors++;
            $display("FAIL ack_pop rdreq=%b vld=%b din=%h exp 1/1/a000", wr_fifo_rdreq, drv_wr_din_vld, drv_wr_din);
        end
        pops = (wr_fifo_rdreq === 1'b1) ? 1 : 0;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            drv_ack = 1'b0; wr_fifo_q = 16'hA000 + 16'(i);
            #1;
            if (i == 1) begin
                checks++;
                if (drv_wr_req !== 1'b0) begin errors++; $display("FAIL req_fall got=%b exp=0", drv_wr_req); end
            end
            if (wr_fifo_rdreq === 1'b1) begin
                pops++;
                if (drv_wr_din !== 16'hA000 + 16'(i)) dbad++;
            end
            if (wr_fifo_rdreq !== 1'(i < 8)) seqbad++;
        end
        checks++;
        if (pops != BL || seqbad != 0 || dbad != 0) begin
            errors++;
            $display("FAIL wr_pops pops=%0d gaps=%0d data_bad=%0d exp 8/0/0", pops, seqbad, dbad);
        end
        $display("init: burst of %0d pops from ack cycle", pops);
    endtask

    task automatic test_read_path();
        int bad, pushes, dbad, seqbad;
        bit got;
        bad = 0; pushes = 0; dbad = 0; seqbad = 0; got = 1'b0;
        rd_en = 1'b1; rd_fifo_usedw = 10'd257;
        repeat (3) begin
            @(negedge clk); #1;
            if (drv_rd_req | drv_wr_req) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rd_space_gate req_cycles=%0d exp=0", bad); end
        rd_fifo_usedw = 10'd256;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk); #1;
            got = drv_rd_req;
        end
        checks++;
        if (!got || drv_rw_addr !== 24'h800000) begin
            errors++;
            $display("FAIL rd_req got=%0d addr=%h exp 1/800000", got, drv_rw_addr);
        end
        drv_ack = 1'b1; rd_en = 1'b0;
        @(negedge clk);
        drv_ack = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drv_rd_dout_vld = 1'b1;
            drv_rd_dout = 16'hB000 + 16'(k);
            #1;
            if (rd_fifo_wrreq === 1'b1) begin
                pushes++;
                if (rd_fifo_data !== 16'hB000 + 16'(k)) dbad++;
            end
            if (rd_fifo_wrreq !== 1'(k < 8)) seqbad++;
            @(negedge clk);
        end
        drv_rd_dout_vld = 1'b0; rd_fifo_usedw = '0;
        checks++;
        if (pushes != BL || seqbad != 0 || dbad != 0) begin
            errors++;
            $display("FAIL rd_pushes pushes=%0d misplaced=%0d data_bad=%0d exp 8/0/0", pushes, seqbad, dbad);
        end
        $display("read: %0d pushes from 10 beats", pushes);
    endtask

    task automatic test_arbitration();
        bit got, is_rd;
        logic [23:0] addr;
        int waited;
        wr_fifo_usedw = 10'd64; rd_fifo_usedw = '0; rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve_burst(1'b0, got, is_rd, addr, waited);
            checks++;
            if (!got || is_rd !== arb_rd[i] || addr !== arb_addr[i]) begin
                errors++;
                $display("FAIL arb_%0d got=%0d rd=%b addr=%h exp rd=%b addr=%h",
                         i, got, is_rd, addr, arb_rd[i], arb_addr[i]);
            end
            $display("arb: burst %0d %s addr=%h", i, is_rd ? "R" : "W", addr);
            if (i == 0) begin
                checks++;
                if (wr_bank !== 2'd1) begin errors++; $display("FAIL wr_rotate got=%0d exp=1", wr_bank); end
            end
            if (i == 1) begin
                checks++;
                if (rd_bank !== 2'd0) begin errors++; $display("FAIL rd_rotate got=%0d exp=0", rd_bank); end
            end
        end
        rd_en = 1'b0; wr_fifo_usedw = '0;
    endtask

    task automatic test_rotation();
        bit got, is_rd;
        logic [23:0] addr;
        int waited, bad;
        bad = 0;
        drv_busy = 1'b1; wr_fifo_usedw = 10'd64;
        repeat (3) begin
            @(negedge clk); #1;
            if (drv_wr_req | drv_rd_req) bad++;
        end
        drv_busy = 1'b0; wr_fifo_usedw = 10'd7;
        repeat (3) begin
            @(negedge clk); #1;
            if (drv_wr_req | drv_rd_req) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL busy_level_gate req_cycles=%0d exp=0", bad); end
        wr_fifo_usedw = 10'd8;
        serve_burst(1'b0, got, is_rd, addr, waited);
        wr_fifo_usedw = '0;
        checks++;
        if (!got || is_rd !== 1'b0 || addr !== 24'h400008 || wr_bank !== 2'd2) begin
            errors++;
            $display("FAIL rot_wr got=%0d rd=%b addr=%h wr_bank=%0d exp W/400008/2", got, is_rd, addr, wr_bank);
        end
        rd_en = 1'b1;
        serve_burst(1'b0, got, is_rd, addr, waited);
        rd_en = 1'b0;
        checks++;
        if (!got || is_rd !== 1'b1 || addr !== 24'h000008 || rd_bank !== 2'd1) begin
            errors++;
            $display("FAIL rot_rd got=%0d rd=%b addr=%h rd_bank=%0d exp R/000008/1", got, is_rd, addr, rd_bank);
        end
        $display("rotation: wr_bank=%0d rd_bank=%0d", wr_bank, rd_bank);
    endtask

    task automatic test_deferral();
        bit got, is_rd;
        logic [23:0] addr;
        int waited;
        wr_fifo_usedw = 10'd64;
        serve_burst(1'b1, got, is_rd, addr, waited);
        checks++;
        if (!got || addr !== 24'h800000) begin
            errors++;
            $display("FAIL defer_first got=%0d addr=%h exp 800000", got, addr);
        end
        serve_burst(1'b0, got, is_rd, addr, waited);
        wr_fifo_usedw = '0;
        checks++;
        if (!got || is_rd !== 1'b0 || addr !== 24'h800000 || wr_bank !== 2'd2) begin
            errors++;
            $display("FAIL defer_sync rd=%b addr=%h wr_bank=%0d exp W/800000/2", is_rd, addr, wr_bank);
        end
        checks++;
        if (waited != 1) begin
            errors++;
            $display("FAIL back_to_back waited=%0d exp=1", waited);
        end
        $display("deferral: post-sync addr=%h wait=%0d", addr, waited);
    endtask

    task automatic test_reset_mid();
        bit got;
        got = 1'b0;
        wr_fifo_usedw = 10'd64; wr_fifo_q = 16'hFFFF;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk); #1;
            got = drv_wr_req;
        end
        checks++;
        if (!got || drv_rw_addr !== 24'h800008) begin
            errors++;
            $display("FAIL mid_req got=%0d addr=%h exp 1/800008", got, drv_rw_addr);
        end
        drv_ack = 1'b1;
        @(negedge clk);
        drv_ack = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (wr_fifo_rdreq !== 1'b1) begin errors++; $display("FAIL mid_in_data rdreq=%b exp=1", wr_fifo_rdreq); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_fifo_rdreq, rd_fifo_wrreq, drv_wr_req, drv_rd_req, drv_wr_din_vld} !== 5'b0 ||
            drv_rw_addr !== 24'h0 || drv_wr_din !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_outs ctrl=%b addr=%h din=%h exp 0",
                     {wr_fifo_rdreq, rd_fifo_wrreq, drv_wr_req, drv_rd_req, drv_wr_din_vld}, drv_rw_addr, drv_wr_din);
        end
        checks++;
        if (wr_bank !== 2'd0 || rd_bank !== 2'd2) begin
            errors++;
            $display("FAIL mid_reset_banks wr=%0d rd=%0d exp 0/2", wr_bank, rd_bank);
        end
        $display("reset_mid: wr_bank=%0d rd_bank=%0d", wr_bank, rd_bank);
        repeat (2) @(negedge clk);
        wr_fifo_usedw = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_init_gating();
        test_read_path();
        test_arbitration();
        test_rotation();
        test_deferral();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
